// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES host sequencer: state encoding and the default
// RUN-phase timeout derived from the core's S-box pipeline depth.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_OUT  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Ten rounds of S-box latency plus slack for key expansion and output muxing.
    function automatic int default_timeout(input int sbox_latency);
        return 10 * sbox_latency + 8;
    endfunction

endpackage

// File: rtl/aes_host_sequencer.sv
// Host-side sequencer for an iterative AES core: accepts one job, pulses the core
// start, waits for core_done with a timeout, and returns the result over a handshake.
module aes_host_sequencer
    import aes_seq_pkg::*;
#(
    parameter int SBOX_LATENCY = 5,
    parameter int DATA_W       = 128,
    parameter int TIMEOUT      = default_timeout(SBOX_LATENCY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_dec,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_key,
    output logic              core_rst,
    output logic              core_dec,
    output logic [DATA_W-1:0] core_data,
    output logic [DATA_W-1:0] core_key,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_dec,
    output logic              busy,
    output logic              error,
    output state_t            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
    // in_ready depends only on state; out_valid/out_data/out_dec hold until out_ready.

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            core_rst  <= 1'b1;
            core_dec  <= 1'b0;
            core_data <= '0;
            core_key  <= '0;
            out_dec   <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    core_rst <= 1'b0;
                    if (in_valid) begin
                        core_dec  <= in_dec;
                        core_data <= in_data;
                        core_key  <= in_key;
                        core_rst  <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                // core_done is deliberately not looked at here: it may be left over.
                S_LOAD: begin
                    core_rst <= 1'b0;
                    cnt      <= '0;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    if (core_done) begin
                        out_data <= core_result;
                        out_dec  <= core_dec;
                        state    <= S_OUT;
                    end else begin
                        if (cnt == CNT_LAST) begin
                            state <= S_ERR;
                        end
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign error     = (state == S_ERR);
    assign dbg_state = state;

endmodule
